// File: rtl/sprite_anim_renderer.sv
// sprite_anim_renderer
// Animated, scaled sprite pixel generator for the VGA layer mux.
// The sprite is placed at a position that is latched once per frame. It is
// magnified by 2**SCALE_LOG2 and fetched from an external synchronous ROM.
// Animation frames advance every ANIM_DIV frame ticks, and a hit-flash FSM
// blinks the sprite for FLASH_TICKS frame ticks.
// Pixel path latency: 2 vga_clk cycles from DrawX/DrawY to pix_on/pix_idx.
// Optional build macro SPRITE_HFLIP_EN adds a facing_left input. facing_left
// is latched with the position, and when set it mirrors the sprite horizontally.
module sprite_anim_renderer #(
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int FRAMES      = 4,
    parameter int SCALE_LOG2  = 1,
    parameter int IDX_W       = 4,
    parameter int TRANS_IDX   = 0,
    parameter int ANIM_DIV    = 8,
    parameter int FLASH_TICKS = 30,
    parameter int ADDR_W      = $clog2(SPR_W * SPR_H * FRAMES)
) (
    input  logic              vga_clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_tick,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              anim_en,
    input  logic              hit,
`ifdef SPRITE_HFLIP_EN
    input  logic              facing_left,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic              pix_on,
    output logic [IDX_W-1:0]  pix_idx,
    output logic              flashing
);

    localparam int LX_W       = $clog2(SPR_W);
    localparam int LY_W       = $clog2(SPR_H);
    localparam int FRM_W      = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int DIV_W      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int FL_W       = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
    localparam int BOX_W      = SPR_W << SCALE_LOG2;
    localparam int BOX_H      = SPR_H << SCALE_LOG2;
    localparam int FRAME_SIZE = SPR_W * SPR_H;

    typedef enum logic {
        NORMAL = 1'b0,
        FLASH  = 1'b1
    } state_t;

    // Latched per-frame placement
    logic [9:0]       px_reg;
    logic [9:0]       py_reg;
`ifdef SPRITE_HFLIP_EN
    logic             flip_reg;
`endif

    // Animation state
    logic [FRM_W-1:0] frame_reg;
    logic [DIV_W-1:0] div_cnt_reg;

    // Hit-flash state
    state_t           state_reg;
    logic [FL_W-1:0]  flash_cnt_reg;
    logic             flashing_reg;

    // Pipeline registers
    logic             in_box_d_reg;
    logic             blank_d_reg;
    logic             vis_d_reg;
    logic             pix_on_reg;
    logic [IDX_W-1:0] pix_idx_reg;

    // Stage 0 combinational signals
    logic [9:0]       dx;
    logic [9:0]       dy;
    logic [10:0]      x_end;
    logic [10:0]      y_end;
    logic             in_box;
    logic [LX_W-1:0]  lx_raw;
    logic [LX_W-1:0]  lx;
    logic [LY_W-1:0]  ly;
    logic             vis;
    logic             opaque;

    // Box bounds are computed in 11 bits so that a sprite overhanging the right
    // or bottom screen edge does not wrap back to column/row 0.
    assign x_end  = {1'b0, px_reg} + 11'(BOX_W);
    assign y_end  = {1'b0, py_reg} + 11'(BOX_H);
    assign dx     = DrawX - px_reg;
    assign dy     = DrawY - py_reg;
    assign in_box = (DrawX >= px_reg) && ({1'b0, DrawX} < x_end) &&
                    (DrawY >= py_reg) && ({1'b0, DrawY} < y_end);
    assign lx_raw = LX_W'(dx >> SCALE_LOG2);
    assign ly     = LY_W'(dy >> SCALE_LOG2);

`ifdef SPRITE_HFLIP_EN
    // SPR_W is a power of two, so SPR_W-1-lx is the bitwise complement of lx
    assign lx = flip_reg ? ~lx_raw : lx_raw;
`else
    assign lx = lx_raw;
`endif

    // ROM address: the frame base plus the row-major offset inside the frame
    assign rom_addr = in_box ? ADDR_W'(32'(frame_reg) * 32'(FRAME_SIZE)
                                     + 32'(ly) * 32'(SPR_W) + 32'(lx))
                             : '0;

    // Visibility: during a flash, the sprite is hidden on odd tick counts
    assign vis    = (state_reg == NORMAL) ? 1'b1 : ~flash_cnt_reg[0];
    assign opaque = in_box_d_reg & blank_d_reg & vis_d_reg &
                    (rom_q != IDX_W'(TRANS_IDX));

    // Position latch: sampled only on frame_tick so that a frame never tears
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            px_reg   <= '0;
            py_reg   <= '0;
`ifdef SPRITE_HFLIP_EN
            flip_reg <= 1'b0;
`endif
        end else if (frame_tick) begin
            px_reg   <= sprite_x;
            py_reg   <= sprite_y;
`ifdef SPRITE_HFLIP_EN
            flip_reg <= facing_left;
`endif
        end
    end

    // Animation divider and frame counter, advanced on enabled frame ticks
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            div_cnt_reg <= '0;
            frame_reg   <= '0;
        end else if (frame_tick && anim_en) begin
            if (div_cnt_reg == DIV_W'(ANIM_DIV - 1)) begin
                div_cnt_reg <= '0;
                frame_reg   <= (frame_reg == FRM_W'(FRAMES - 1)) ? '0 : frame_reg + 1'b1;
            end else begin
                div_cnt_reg <= div_cnt_reg + 1'b1;
            end
        end
    end

    // Hit-flash FSM. A hit always (re)starts the flash, even on a frame_tick cycle.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_reg     <= NORMAL;
            flash_cnt_reg <= '0;
            flashing_reg  <= 1'b0;
        end else if (hit) begin
            state_reg     <= FLASH;
            flash_cnt_reg <= '0;
            flashing_reg  <= 1'b1;
        end else begin
            case (state_reg)
                NORMAL: begin
                    flashing_reg <= 1'b0;
                end
                FLASH: begin
                    if (frame_tick) begin
                        if (flash_cnt_reg == FL_W'(FLASH_TICKS - 1)) begin
                            state_reg     <= NORMAL;
                            flash_cnt_reg <= '0;
                            flashing_reg  <= 1'b0;
                        end else begin
                            flash_cnt_reg <= flash_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg    <= NORMAL;
                    flashing_reg <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1 delays the box/blank/visibility qualifiers to line up with rom_q,
    // and the output register forms the final pixel.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            in_box_d_reg <= 1'b0;
            blank_d_reg  <= 1'b0;
            vis_d_reg    <= 1'b0;
            pix_on_reg   <= 1'b0;
            pix_idx_reg  <= '0;
        end else begin
            in_box_d_reg <= in_box;
            blank_d_reg  <= blank;
            vis_d_reg    <= vis;
            pix_on_reg   <= opaque;
            pix_idx_reg  <= opaque ? rom_q : '0;
        end
    end

    assign pix_on   = pix_on_reg;
    assign pix_idx  = pix_idx_reg;
    assign flashing = flashing_reg;

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Directed testbench for sprite_anim_renderer at the default parameters
// (32x32 sprite, 4 frames, scale x2, 4-bit index, ANIM_DIV 8, FLASH_TICKS 30).
// The bench drives rom_q directly, acting as the ROM's registered output.
module tb_sprite_anim_renderer;

    logic        vga_clk;
    logic        Reset;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        frame_tick;
    logic [9:0]  sprite_x;
    logic [9:0]  sprite_y;
    logic        anim_en;
    logic        hit;
`ifdef SPRITE_HFLIP_EN
    logic        facing_left;
`endif
    logic [11:0] rom_addr;
    logic [3:0]  rom_q;
    logic        pix_on;
    logic [3:0]  pix_idx;
    logic        flashing;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    sprite_anim_renderer dut (
        .vga_clk    (vga_clk),
        .Reset      (Reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .frame_tick (frame_tick),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .anim_en    (anim_en),
        .hit        (hit),
`ifdef SPRITE_HFLIP_EN
        .facing_left(facing_left),
`endif
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .pix_on     (pix_on),
        .pix_idx    (pix_idx),
        .flashing   (flashing)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // One comparison: counts it, asserts equality, and reports one line
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp)
            $display("check %-16s observed %0d expected %0d ok", tag, obs, exp);
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge
    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic pulse_frame_tick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    // Present a pixel, check its ROM address, feed the ROM data one cycle
    // later, and check the registered pixel one cycle after that.
    task automatic pix_test(input string tag, input int x, input int y,
                            input int exp_addr, input int q, input int exp_on);
        DrawX = 10'(x);
        DrawY = 10'(y);
        #1;
        chk({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
        tick();
        rom_q = 4'(q);
        tick();
        chk({tag, "_on"}, 32'(pix_on), 32'(exp_on));
        chk({tag, "_idx"}, 32'(pix_idx), exp_on ? 32'(q) : 32'd0);
    endtask

    initial begin
        Reset      = 1'b1;
        DrawX      = '0;
        DrawY      = '0;
        blank      = 1'b1;
        frame_tick = 1'b0;
        sprite_x   = '0;
        sprite_y   = '0;
        anim_en    = 1'b0;
        hit        = 1'b0;
        rom_q      = '0;
`ifdef SPRITE_HFLIP_EN
        facing_left = 1'b0;
`endif
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        chk("rst_pix_on", 32'(pix_on), 32'd0);
        chk("rst_pix_idx", 32'(pix_idx), 32'd0);
        chk("rst_flashing", 32'(flashing), 32'd0);

        // 1: latch position (100,50)
        sprite_x = 10'd100;
        sprite_y = 10'd50;
        pulse_frame_tick();
        DrawX = 10'd100; DrawY = 10'd50; #1;
        chk("latch_origin", 32'(rom_addr), 32'd0);
        DrawX = 10'd102; #1;
        chk("latch_lx1", 32'(rom_addr), 32'd1);

        // 2: scaled pixel, opaque and transparent
        pix_test("px65_opq", 103, 55, 65, 7, 1);
        pix_test("px65_trn", 103, 55, 65, 0, 0);
        // blanked video suppresses the pixel
        blank = 1'b0;
        pix_test("blanked", 103, 55, 65, 7, 0);
        blank = 1'b1;

        // 3: box edges
        pix_test("right_in", 163, 55, 95, 5, 1);
        pix_test("right_out", 164, 55, 0, 5, 0);
        pix_test("bot_in", 100, 113, 992, 5, 1);
        pix_test("bot_out", 100, 114, 0, 5, 0);
        pix_test("left_out", 99, 55, 0, 5, 0);

        // a box overhanging column 1023 must not wrap (needs 11-bit compare)
        sprite_x = 10'd1000;
        pulse_frame_tick();
        pix_test("wrap_in", 1010, 50, 5, 9, 1);
        sprite_x = 10'd100;
        pulse_frame_tick();

        // 4: animation, frame base visible on rom_addr at the sprite origin
        DrawX = 10'd100; DrawY = 10'd50;
        anim_en = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            pulse_frame_tick();
            if ((i % 4) == 0)
                chk($sformatf("anim_t%0d", i), 32'(rom_addr), 32'(((i / 8) % 4) * 1024));
        end
        repeat (9) pulse_frame_tick();
        chk("anim_f1", 32'(rom_addr), 32'd1024);
        anim_en = 1'b0;
        repeat (20) pulse_frame_tick();
        chk("anim_hold", 32'(rom_addr), 32'd1024);
        anim_en = 1'b1;
        repeat (6) pulse_frame_tick();
        chk("anim_div_held", 32'(rom_addr), 32'd1024);
        pulse_frame_tick();
        chk("anim_f2", 32'(rom_addr), 32'd2048);
        anim_en = 1'b0;

        // 5: hit flash, steady opaque in-box pixel
        DrawX = 10'd103; DrawY = 10'd55; rom_q = 4'd7;
        hit = 1'b1;
        tick();
        hit = 1'b0;
        chk("flash_start", 32'(flashing), 32'd1);
        for (int t = 1; t <= 30; t++) begin
            pulse_frame_tick();
            repeat (2) tick();
            if (t == 1 || t == 2 || t == 29 || t == 30) begin
                chk($sformatf("flash_t%0d", t), 32'(flashing), (t < 30) ? 32'd1 : 32'd0);
                chk($sformatf("flpix_t%0d", t), 32'(pix_on),
                    (t < 30) ? ((t % 2 == 0) ? 32'd1 : 32'd0) : 32'd1);
            end
        end

        // restart: hit after tick 10 extends the flash to tick 40
        hit = 1'b1;
        tick();
        hit = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            pulse_frame_tick();
            if (t == 10) begin
                hit = 1'b1;
                tick();
                hit = 1'b0;
            end
            if (t == 30 || t == 39 || t == 40)
                chk($sformatf("restart_t%0d", t), 32'(flashing), (t < 40) ? 32'd1 : 32'd0);
        end

        // hit and frame_tick together: hit wins, flash_cnt = 0 (visible)
        hit = 1'b1; frame_tick = 1'b1;
        tick();
        hit = 1'b0; frame_tick = 1'b0;
        repeat (2) tick();
        chk("hit_tick_flash", 32'(flashing), 32'd1);
        chk("hit_tick_pix", 32'(pix_on), 32'd1);
        pulse_frame_tick();
        repeat (2) tick();
        chk("hit_tick_odd", 32'(pix_on), 32'd0);
        pulse_frame_tick();
        repeat (2) tick();
        chk("pre_rst_pix", 32'(pix_on), 32'd1);

        // 6: reset mid-line
        Reset = 1'b1;
        tick();
        chk("midrst_pix_on", 32'(pix_on), 32'd0);
        chk("midrst_pix_idx", 32'(pix_idx), 32'd0);
        chk("midrst_flash", 32'(flashing), 32'd0);
        Reset = 1'b0;
        DrawX = 10'd2; DrawY = 10'd2; #1;
        chk("midrst_addr", 32'(rom_addr), 32'd33);
        tick();
        chk("midrst_pipe", 32'(pix_on), 32'd0);
        tick();
        chk("midrst_normal", 32'(pix_on), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
